// File: rtl/ram_io_port_arbiter_if.sv
// Bundle of both requester ports plus the single-port RAM bus for ram_io_port_arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface ram_io_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              A_req, A_we, A_lock, A_ack, A_rvalid;
  logic [ADDR_W-1:0] A_addr;
  logic [DATA_W-1:0] A_wdata, A_rdata;
  logic              B_req, B_we, B_lock, B_ack, B_rvalid;
  logic [ADDR_W-1:0] B_addr;
  logic [DATA_W-1:0] B_wdata, B_rdata;
  logic              RAM_EN, RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DIN, RAM_DOUT;

  modport slave (
    input  A_req, A_we, A_addr, A_wdata, A_lock,
    output A_ack, A_rvalid, A_rdata,
    input  B_req, B_we, B_addr, B_wdata, B_lock,
    output B_ack, B_rvalid, B_rdata,
    output RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN,
    input  RAM_DOUT
  );

  modport master (
    output A_req, A_we, A_addr, A_wdata, A_lock,
    input  A_ack, A_rvalid, A_rdata,
    output B_req, B_we, B_addr, B_wdata, B_lock,
    input  B_ack, B_rvalid, B_rdata,
    input  RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN,
    output RAM_DOUT
  );
endinterface

// File: rtl/ram_io_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM; IDLE/ISSUE/WAIT/RESP per access.
// Optional lock bursts (up to 4 owned transactions) are enabled by defining RAM_IO_BURST_EN.
module ram_io_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic                    CLK,
  input logic                    reset,
  ram_io_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              win, win_nx;   // 0 = A, 1 = B
  logic              rr, rr_nx;     // 0 = A has priority on contention
  logic              cap_we, cap_we_nx;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nx;
  logic [DATA_W-1:0] cap_wdata, cap_wdata_nx;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              sel;

`ifdef RAM_IO_BURST_EN
  logic [2:0] burst_cnt, burst_cnt_nx, cnt_new;
  logic       own_req, own_lock, hold, eff_rr, sel_lock;
`else
  logic       unused_lock;
  assign unused_lock = bus.A_lock ^ bus.B_lock;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      win       <= 1'b0;
      rr        <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
`ifdef RAM_IO_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state     <= state_nx;
      win       <= win_nx;
      rr        <= rr_nx;
      cap_we    <= cap_we_nx;
      cap_addr  <= cap_addr_nx;
      cap_wdata <= cap_wdata_nx;
`ifdef RAM_IO_BURST_EN
      burst_cnt <= burst_cnt_nx;
`endif
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == WAIT && !cap_we) begin
      if (win) b_rdata <= bus.RAM_DOUT;
      else     a_rdata <= bus.RAM_DOUT;
    end
  end

  always_comb begin
    state_nx     = state;
    win_nx       = win;
    rr_nx        = rr;
    cap_we_nx    = cap_we;
    cap_addr_nx  = cap_addr;
    cap_wdata_nx = cap_wdata;
`ifdef RAM_IO_BURST_EN
    burst_cnt_nx = burst_cnt;
    own_req  = win ? bus.B_req  : bus.A_req;
    own_lock = win ? bus.B_lock : bus.A_lock;
    hold     = (burst_cnt != 3'd0) && own_req && own_lock;
    // A burst ending on lock/req drop hands contention priority to the other side.
    eff_rr   = (burst_cnt != 3'd0) ? ~win : rr;
    sel      = hold ? win : ((bus.A_req && bus.B_req) ? eff_rr : bus.B_req);
    sel_lock = sel ? bus.B_lock : bus.A_lock;
    cnt_new  = hold ? burst_cnt + 3'd1 : 3'd1;
`else
    sel      = (bus.A_req && bus.B_req) ? rr : bus.B_req;
`endif
    unique case (state)
      IDLE: begin
        if (bus.A_req || bus.B_req) begin
          state_nx     = ISSUE;
          win_nx       = sel;
          cap_we_nx    = sel ? bus.B_we    : bus.A_we;
          cap_addr_nx  = sel ? bus.B_addr  : bus.A_addr;
          cap_wdata_nx = sel ? bus.B_wdata : bus.A_wdata;
`ifdef RAM_IO_BURST_EN
          if (sel_lock && cnt_new < 3'd4) begin
            burst_cnt_nx = cnt_new;
          end else begin
            burst_cnt_nx = '0;
            rr_nx        = ~sel;
          end
`else
          rr_nx        = ~sel;
`endif
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.A_ack    = 1'b0;
    bus.B_ack    = 1'b0;
    bus.A_rvalid = 1'b0;
    bus.B_rvalid = 1'b0;
    bus.RAM_EN   = 1'b0;
    bus.RAM_WE   = 1'b0;
    bus.RAM_ADDR = '0;
    bus.RAM_DIN  = '0;
    if (state == ISSUE) begin
      bus.RAM_EN   = 1'b1;
      bus.RAM_WE   = cap_we;
      bus.RAM_ADDR = cap_addr;
      bus.RAM_DIN  = cap_wdata;
      bus.A_ack    = ~win;
      bus.B_ack    = win;
    end
    if (state == RESP) begin
      bus.A_rvalid = ~win;
      bus.B_rvalid = win;
    end
  end

  assign bus.A_rdata = a_rdata;
  assign bus.B_rdata = b_rdata;
endmodule

// File: tb/tb_ram_io_port_arbiter.sv
// Directed self-checking bench for ram_io_port_arbiter with a 1-cycle-latency RAM model.
// Burst expectations follow RAM_IO_BURST_EN when it is defined for the build.
module tb_ram_io_port_arbiter;
  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [256];
  logic [7:0] ram_dout;

  ram_io_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_io_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = i[7:0] ^ 8'h3C;
    if (i == 'h12) v = 8'h5A;
    if (i == 'h03) v = 8'h77;
    if (i == 'h10) v = 8'hA1;
    if (i == 'h20) v = 8'hB2;
    return v;
  endfunction

  // RAM model: read-before-write, data valid the cycle after RAM_EN.
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus.RAM_EN) begin
      if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DIN;
      ram_dout <= mem[bus.RAM_ADDR];
    end
  end
  assign bus.RAM_DOUT = ram_dout;

  function automatic logic [63:0] outs();
    return {26'd0, bus.A_ack, bus.A_rvalid, bus.A_rdata, bus.B_ack, bus.B_rvalid, bus.B_rdata,
            bus.RAM_EN, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DIN};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic       exp_b;
    logic [7:0] got;
    reset = 1'b1;
    bus.A_req = 0; bus.A_we = 0; bus.A_addr = '0; bus.A_wdata = '0; bus.A_lock = 0;
    bus.B_req = 0; bus.B_we = 0; bus.B_addr = '0; bus.B_wdata = '0; bus.B_lock = 0;
    repeat (2) step();
    chk("reset_outputs", outs(), 64'd0);

    // A read of 0x12; req dropped and addr changed in the ISSUE cycle
    reset = 1'b0;
    bus.A_req = 1; bus.A_we = 0; bus.A_addr = 8'h12;
    step();
    chk("a_read_issue", {bus.A_ack, bus.B_ack, bus.RAM_EN, bus.RAM_WE, bus.RAM_ADDR}, {4'b1010, 8'h12});
    bus.A_req = 0; bus.A_addr = 8'h55;
    step();
    chk("a_read_wait_quiet", outs(), 64'd0);
    step();
    chk("a_read_resp", {bus.A_rvalid, bus.B_rvalid, bus.A_rdata}, {2'b10, 8'h5A});
    step();
    chk("a_read_idle", {bus.A_rvalid, bus.A_ack, bus.RAM_EN}, 3'b000);
    step(); step();
    chk("a_no_second_ack", {bus.A_ack, bus.B_ack, bus.RAM_EN}, 3'b000);

    // B write 0x03 <= 0xC3; B_rdata must not pick up the old RAM word
    bus.B_req = 1; bus.B_we = 1; bus.B_addr = 8'h03; bus.B_wdata = 8'hC3;
    step();
    chk("b_write_issue", {bus.A_ack, bus.B_ack, bus.RAM_EN, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DIN},
        {4'b0111, 8'h03, 8'hC3});
    bus.B_req = 0; bus.B_we = 0;
    step(); step();
    chk("b_write_resp", {bus.A_rvalid, bus.B_rvalid, bus.B_rdata}, {2'b01, 8'h00});
    step();
    bus.B_req = 1;
    step();
    chk("b_read_issue", {bus.A_ack, bus.B_ack, bus.RAM_WE, bus.RAM_ADDR}, {3'b010, 8'h03});
    bus.B_req = 0;
    step(); step();
    chk("b_read_resp", {bus.B_rvalid, bus.B_rdata, bus.A_rdata}, {1'b1, 8'hC3, 8'h5A});
    step();

    // Contention after reset: A first, then strict alternation
    reset = 1'b1; step(); reset = 1'b0;
    bus.A_req = 1; bus.A_addr = 8'h10; bus.B_req = 1; bus.B_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2) == 1;
      step();
      chk($sformatf("rr_ack_%0d", i), {bus.A_ack, bus.B_ack}, exp_b ? 2'b01 : 2'b10);
      step(); step();
      got = exp_b ? bus.B_rdata : bus.A_rdata;
      chk($sformatf("rr_resp_%0d", i), {bus.A_rvalid, bus.B_rvalid, got},
          exp_b ? {2'b01, 8'hB2} : {2'b10, 8'hA1});
      step();
    end
    bus.A_req = 0; bus.B_req = 0;
    step();

    // A holds lock under continuous contention
    reset = 1'b1; step(); reset = 1'b0;
    bus.A_req = 1; bus.A_lock = 1; bus.B_req = 1;
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_IO_BURST_EN
      exp_b = (i == 4);
`else
      exp_b = (i % 2) == 1;
`endif
      step();
      chk($sformatf("lock_ack_%0d", i), {bus.A_ack, bus.B_ack}, exp_b ? 2'b01 : 2'b10);
      step(); step(); step();
    end
    bus.A_req = 0; bus.A_lock = 0; bus.B_req = 0;
    step();

    // Reset pulsed in WAIT aborts the transaction
    bus.A_req = 1; bus.A_addr = 8'h12;
    step();
    chk("abort_issue", {bus.A_ack, bus.B_ack}, 2'b10);
    bus.A_req = 0;
    step();
    reset = 1'b1;
    #1;
    chk("abort_async_outputs", outs(), 64'd0);
    step();
    chk("abort_reset_held", outs(), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort_quiet_%0d", i), {bus.A_ack, bus.B_ack, bus.A_rvalid, bus.B_rvalid}, 4'b0000);
    end
    bus.A_req = 1; bus.A_addr = 8'h10;
    step();
    chk("post_reset_issue", {bus.A_ack, bus.RAM_EN, bus.RAM_ADDR}, {2'b11, 8'h10});
    bus.A_req = 0;
    step(); step();
    chk("post_reset_resp", {bus.A_rvalid, bus.A_rdata}, {1'b1, 8'hA1});
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_io_port_arbiter.md
RAM_IO_PORT_ARBITER -- requirements
Module: ram_io_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Ports A_req / B_req  in  1  requester wants one RAM access; held until its ack.
REQ-007 Ports A_we / B_we  in  1  1=write, 0=read; stable while req is high.
REQ-008 Ports A_addr / B_addr  in  ADDR_W  access address; stable while req is high.
REQ-009 Ports A_wdata / B_wdata  in  DATA_W  write data; stable while req is high.
REQ-010 Ports A_lock / B_lock  in  1  burst-ownership request, sampled with req.
REQ-011 Ports A_ack / B_ack  out  1  one-cycle pulse: request captured and issued to RAM.
REQ-012 Ports A_rvalid / B_rvalid  out  1  one-cycle completion pulse, for reads and writes.
REQ-013 Ports A_rdata / B_rdata  out  DATA_W  read data, valid only while the matching rvalid is high.
REQ-014 Ports RAM_EN, RAM_WE  out  1  RAM strobe and write enable.
REQ-015 Ports RAM_ADDR  out  ADDR_W and RAM_DIN  out  DATA_W  RAM address and write data.
REQ-016 Port RAM_DOUT  in  DATA_W  RAM read data, valid exactly 1 cycle after an RAM_EN cycle.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; every transaction SHALL pass through all four in order, one cycle each.
REQ-018 In IDLE, when any req is high, the arbiter SHALL pick a winner, capture its we/addr/wdata, and move to ISSUE; with no req it SHALL stay in IDLE.
REQ-019 Selection: exactly one req high -> that requester wins; both high -> the requester indicated by round-robin pointer rr wins.
REQ-020 rr SHALL point to the non-winner after each grant.
REQ-021 In ISSUE: RAM_EN=1; RAM_WE, RAM_ADDR and RAM_DIN from the captured values; the winner's ack=1.
REQ-022 In WAIT the arbiter SHALL register RAM_DOUT into the winner's rdata; on writes rdata SHALL hold its previous value.
REQ-023 In RESP the winner's rvalid SHALL be 1, then the FSM SHALL return to IDLE.
REQ-024 Timing: req sampled at IDLE edge k -> ack at cycle k+1 -> rvalid at cycle k+3; maximum throughput is one transaction per 4 cycles.
REQ-025 At most one ack and one rvalid SHALL be high in any cycle; outputs of the non-winner SHALL stay 0.
REQ-026 A req dropped or changed after capture SHALL NOT alter the transaction in flight.
REQ-027 RAM_EN, RAM_WE, RAM_ADDR and RAM_DIN SHALL be 0 outside ISSUE.

Reset
REQ-028 While reset is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, rr SHALL point to A, and any burst count SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack or rvalid afterwards; the first arbitration SHALL take place on the first edge after reset deasserts.

Configuration
REQ-030 Macro RAM_IO_BURST_EN, defined: a winner that has its lock high at capture SHALL keep ownership for up to 4 consecutive transactions. The other requester is ignored while the winner's req and lock stay high. rr SHALL update only when the burst ends (lock low, req low, or 4th transaction).
REQ-031 Macro RAM_IO_BURST_EN, undefined: A_lock and B_lock SHALL remain as ports but SHALL be ignored, with pure round-robin arbitration.

Verification
REQ-032 Scenario: A read, addr 0x12, RAM holds 0x5A -> A_ack at k+1 with RAM_EN=1, RAM_ADDR=0x12; A_rvalid at k+3 with A_rdata=0x5A.
REQ-033 Scenario: A and B requests at the same edge after reset -> A served first, B acked 4 cycles after A_ack; repeated contention alternates A,B,A,B.
REQ-034 Scenario: B write addr 0x03 data 0xC3 -> RAM_WE=1, RAM_DIN=0xC3 in the ack cycle; B_rvalid 2 cycles later; B_rdata unchanged.
REQ-035 Scenario: reset pulsed during WAIT -> no rvalid; outputs 0; a new A request after reset is acked at k+1.
REQ-036 Scenario (RAM_IO_BURST_EN): A lock=1, both requesters continuously requesting -> 4 consecutive A acks, then B acked; without the macro -> A,B alternation.
REQ-037 Scenario: A drops req in the ISSUE cycle -> transaction still completes with A_rvalid; no second A ack.
